// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the tt_sweep truth-table sequencer.
// Optional feature macro used by the top: TT_SWEEP_SYNC_EN.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    TT_IDLE  = 2'd0,
    TT_DRIVE = 2'd1,
    TT_DONE  = 2'd2
  } tt_state_e;

  localparam int TT_NUM_VEC = 8;
  localparam int TT_IDX_W   = 3;
  localparam int TT_WORD_W  = 8;

  // Append one sample at the LSB so the first vector ends up at the MSB.
  function automatic logic [TT_WORD_W-1:0] tt_shift(input logic [TT_WORD_W-1:0] word,
                                                    input logic                 bit_in);
    return {word[TT_WORD_W-2:0], bit_in};
  endfunction

endpackage

// File: rtl/tt_sweep_sync2.sv
// Two-flop synchronizer, async active-low reset to 0.
module tt_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Synchronizer chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/tt_sweep.sv
// Truth-table sequencer: drives all 8 vectors into a 3-input block and assembles its output word.
// Define TT_SWEEP_SYNC_EN to pass out_i through a 2-flop synchronizer before sampling.
module tt_sweep
  import tt_sweep_pkg::*;
#(
  parameter int              SETTLE_CYCLES = 4,
  parameter logic [7:0]      EXPECTED      = 8'hA9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       out_i,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] tt_word
);

  localparam int              CNT_W      = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [TT_IDX_W-1:0] IDX_LAST = TT_IDX_W'(TT_NUM_VEC - 1);

  tt_state_e               state_r, state_s;
  logic [TT_IDX_W-1:0]     idx_r, idx_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic [TT_WORD_W-1:0]    word_r, word_s;
  logic                    busy_r, busy_s;
  logic                    done_r, done_s;
  logic                    pass_r, pass_s;
  logic                    sample_s;

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("tt_sweep: SETTLE_CYCLES must be >= 1");
  end

`ifdef TT_SWEEP_SYNC_EN
  // The synchronizer eats two cycles of each hold, so shorter holds would sample stale data.
  if (SETTLE_CYCLES < 3) begin : g_bad_settle_sync
    $error("tt_sweep: SETTLE_CYCLES must be >= 3 with TT_SWEEP_SYNC_EN");
  end

  tt_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (out_i),
    .q     (sample_s)
  );
`else
  assign sample_s = out_i;
`endif

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= TT_IDLE;
      idx_r   <= '0;
      cnt_r   <= '0;
      word_r  <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      cnt_r   <= cnt_s;
      word_r  <= word_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      pass_r  <= pass_s;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    cnt_s   = cnt_r;
    word_s  = word_r;
    busy_s  = busy_r;
    done_s  = done_r;
    pass_s  = pass_r;
    case (state_r)
      TT_IDLE, TT_DONE: begin
        if (start) begin
          state_s = TT_DRIVE;
          idx_s   = '0;
          cnt_s   = CNT_RELOAD;
          word_s  = '0;
          busy_s  = 1'b1;
          done_s  = 1'b0;
          pass_s  = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      TT_DRIVE: begin
        if (cnt_r == '0) begin
          word_s = tt_shift(word_r, sample_s);
          if (idx_r == IDX_LAST) begin
            // Vector returns to 000 so the block is left in a known input state.
            state_s = TT_DONE;
            idx_s   = '0;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            pass_s  = (word_s == EXPECTED);
          end else begin
            idx_s = idx_r + TT_IDX_W'(1);
            cnt_s = CNT_RELOAD;
          end
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_s = TT_IDLE;
        idx_s   = '0;
        cnt_s   = '0;
        word_s  = '0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        pass_s  = 1'b0;
      end
    endcase
  end

  assign {in1, in2, in3} = idx_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign pass            = pass_r;
  assign tt_word         = word_r;

endmodule
